// File: rtl/tff.sv
// -----------------------------------------------------------------------------
// tff -- bank of independent toggle flip-flops with complementary outputs.
//
// Each bit of q inverts on a rising clock edge when its t bit is high, and
// holds otherwise. A high reset at a rising edge loads RESET_VAL into every
// bit, regardless of t. The first edge with reset low resumes normal toggling
// from RESET_VAL.
//
// Before the first reset edge the state is undefined. Toggling it leaves it
// undefined.
//
// Parameters:
//   WIDTH      number of independent toggle bits (t, q, qb are WIDTH wide)
//   RESET_VAL  value loaded into q by reset; qb gets its complement
//
// Ports:
//   clock  in   1      rising-edge clock, the only clock
//   reset  in   1      synchronous active-high reset
//   t      in   WIDTH  per-bit toggle enable, sampled on rising edge
//   q      out  WIDTH  registered state
//   qb     out  WIDTH  ~q, derived from the same register as q
// -----------------------------------------------------------------------------
module tff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] next_s;

   // Next-state selection: reset wins over any toggle request.
   always_comb begin
      next_s = state_r;
      if (reset) begin
         next_s = RESET_VAL;
      end else begin
         // XOR with t inverts exactly the enabled bits, so bits stay independent.
         next_s = state_r ^ t;
      end
   end

   // State register, updated only on the rising edge of clock.
   always_ff @(posedge clock) begin
      state_r <= next_s;
   end

   // qb comes from the same flop as q, so the two outputs never disagree.
   assign q  = state_r;
   assign qb = ~state_r;

endmodule

// File: tb/tb_tff.sv
// -----------------------------------------------------------------------------
// tb_tff -- self-checking bench for tff.
//
// The bench drives two instances side by side:
//   - u1: default parameters (WIDTH=1, RESET_VAL=0)
//   - u4: WIDTH=4, RESET_VAL=4'b1010
//
// The reference model does not track q directly. It counts how many toggles
// each bit has taken since the last reset. The expected q is then RESET_VAL
// XOR the parity of that count.
//
// A compare process checks both instances on every falling edge once a reset
// has been seen. Directed steps add literal checks that pin the model.
// -----------------------------------------------------------------------------
module tb_tff;

   localparam logic [3:0] RV4 = 4'b1010;

   logic       clock;
   logic       reset;
   logic       t1;
   logic [3:0] t4;
   logic       q1;
   logic       qb1;
   logic [3:0] q4;
   logic [3:0] qb4;

   int errors = 0;
   int checks = 0;

   // Reference model state: toggle counts since the last reset.
   int  cnt1;
   int  cnt4 [4];
   bit  valid = 1'b0;

   tff u1 (
      .clock (clock),
      .reset (reset),
      .t     (t1),
      .q     (q1),
      .qb    (qb1)
   );

   tff #(.WIDTH(4), .RESET_VAL(RV4)) u4 (
      .clock (clock),
      .reset (reset),
      .t     (t4),
      .q     (q4),
      .qb    (qb4)
   );

   // 20 ns clock period.
   initial clock = 1'b0;
   always #10 clock = ~clock;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge, from the inputs sampled there.
   always @(posedge clock) begin
      if (reset) begin
         cnt1 <= 0;
         for (int i = 0; i < 4; i++) cnt4[i] <= 0;
         valid <= 1'b1;
      end else if (valid) begin
         cnt1 <= cnt1 + int'(t1);
         for (int i = 0; i < 4; i++) cnt4[i] <= cnt4[i] + int'(t4[i]);
      end
   end

   function automatic logic [3:0] exp4();
      logic [3:0] e;
      for (int i = 0; i < 4; i++) e[i] = RV4[i] ^ cnt4[i][0];
      return e;
   endfunction

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clock) begin
      if (valid) begin
         chk("model_q1",  {3'b000, q1},  {3'b000, cnt1[0]});
         chk("model_qb1", {3'b000, qb1}, {3'b000, ~cnt1[0]});
         chk("model_q4",  q4,  exp4());
         chk("model_qb4", qb4, ~exp4());
      end
   end

   // Drive one cycle on the falling edge, then wait until just after the
   // following rising edge.
   task automatic cyc(input logic r, input logic tt1, input logic [3:0] tt4);
      @(negedge clock);
      reset = r;
      t1    = tt1;
      t4    = tt4;
      @(posedge clock);
      #1;
   endtask

   task automatic lit(input string name, input logic e1, input logic [3:0] e4);
      chk({name, "_q1"},  {3'b000, q1},  {3'b000, e1});
      chk({name, "_qb1"}, {3'b000, qb1}, {3'b000, ~e1});
      chk({name, "_q4"},  q4,  e4);
      chk({name, "_qb4"}, qb4, ~e4);
   endtask

   initial begin
      reset = 1'b0;
      t1    = 1'b0;
      t4    = 4'b0000;

      // Pre-reset: state undefined, nothing compared.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'b0000);

      // Reset.
      cyc(1'b1, 1'b0, 4'b0000);
      lit("reset", 1'b0, 4'b1010);

      // Hold.
      cyc(1'b0, 1'b0, 4'b0000);
      lit("hold0", 1'b0, 4'b1010);
      cyc(1'b0, 1'b0, 4'b0000);
      lit("hold1", 1'b0, 4'b1010);

      // Single toggle, then hold.
      cyc(1'b0, 1'b1, 4'b0110);
      lit("toggle", 1'b1, 4'b1100);
      cyc(1'b0, 1'b0, 4'b0000);
      lit("thold0", 1'b1, 4'b1100);
      cyc(1'b0, 1'b0, 4'b0000);
      lit("thold1", 1'b1, 4'b1100);

      // Continuous toggle from reset.
      cyc(1'b1, 1'b0, 4'b0000);
      lit("reset2", 1'b0, 4'b1010);
      cyc(1'b0, 1'b1, 4'b1111);
      lit("cont0", 1'b1, 4'b0101);
      cyc(1'b0, 1'b1, 4'b1111);
      lit("cont1", 1'b0, 4'b1010);
      cyc(1'b0, 1'b1, 4'b1111);
      lit("cont2", 1'b1, 4'b0101);
      cyc(1'b0, 1'b1, 4'b1111);
      lit("cont3", 1'b0, 4'b1010);

      // Reset priority over a pending toggle.
      cyc(1'b0, 1'b1, 4'b0001);
      lit("prio_pre", 1'b1, 4'b1011);
      cyc(1'b1, 1'b1, 4'b1111);
      lit("prio_rst", 1'b0, 4'b1010);
      cyc(1'b0, 1'b1, 4'b1111);
      lit("prio_post", 1'b1, 4'b0101);

      // Multi-cycle reset with t high: t ignored throughout.
      cyc(1'b1, 1'b1, 4'b1111);
      lit("rhold0", 1'b0, 4'b1010);
      cyc(1'b1, 1'b1, 4'b1111);
      lit("rhold1", 1'b0, 4'b1010);

      // Reset pulse between edges has no effect.
      cyc(1'b0, 1'b1, 4'b1000);
      lit("glitch_pre", 1'b1, 4'b0010);
      @(negedge clock);
      t1    = 1'b0;
      t4    = 4'b0000;
      #2 reset = 1'b1;
      #3 reset = 1'b0;
      @(posedge clock);
      #1;
      lit("glitch", 1'b1, 4'b0010);

      // Random traffic, checked by the model only.
      for (int i = 0; i < 40; i++) begin
         cyc(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
             1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      end

      @(negedge clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tff.md
Name: tff

Overview:
- Single-clock toggle flip-flop with complementary outputs.
- Synchronous, active-high reset.
- When toggle input t is high at a rising clock edge, the stored state inverts; otherwise it holds.
- Leaf cell for counters, dividers and lab-level sequential blocks. Width is parameterised so one instance can hold a bank of independent toggle bits.

Parameters:
- WIDTH, 1, number of independent toggle bits; t, q and qb are all WIDTH bits wide.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by reset; qb takes its bitwise complement.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- t  input  WIDTH  toggle enable per bit, sampled on the rising edge of clock.
- q  output  WIDTH  registered state.
- qb  output  WIDTH  bitwise complement of q.

Behaviour:
- One clock; reset is synchronous and active-high.
- All state changes occur only on a rising edge of clock. No asynchronous paths into the state.
- Priority at each rising edge:
  - reset=1: q <= RESET_VAL, whatever t is.
  - reset=0 and t[i]=1: q[i] <= ~q[i].
  - reset=0 and t[i]=0: q[i] holds.
- Bits are fully independent. A toggle on one bit never affects another.
- qb equals ~q at all times. It is derived combinationally from the q register, not from a second flop, so the two outputs never disagree, even for one delta.
- Latency: one clock. The effect of t or reset sampled at edge N is visible on q/qb right after edge N.
- Reset values with default parameters: q=0, qb=1.
- State before the first reset edge is undefined: X in simulation, unknown in silicon.
  - Toggling an undefined state leaves it undefined.
  - Users must apply reset before relying on q.
- Reset held for several cycles: q stays at RESET_VAL for every one of those edges; t is ignored throughout.
- Reset mid-sequence: the edge with reset=1 overrides any pending toggle. The first edge with reset=0 resumes normal t sampling from RESET_VAL.
- Reset pulse that does not span a rising edge has no effect, because reset is synchronous.
- t held high continuously: q alternates every cycle, giving a divide-by-2 of clock on each bit.
- Inputs are assumed stable around the rising edge. Benches drive them on the falling edge.

Test Plan:
- Reset: clock period 20 ns; set reset=1 at a falling edge, release at the next falling edge -> after the intervening rising edge q=0, qb=1.
- Hold: after reset, t=0 for 2 cycles -> q stays 0, qb stays 1 on each edge.
- Single toggle: after reset, drive t=1 for one cycle, then t=0 for two cycles -> q=1, qb=0 after the toggle edge, then holds at 1/0.
- Continuous toggle: after reset, t=1 for 4 cycles -> q sequence 1,0,1,0; qb always its inverse.
- Reset priority: with q=1 and t=1, assert reset for one edge -> q=0, qb=1 (no toggle). Next edge with reset=0, t=1 -> q=1.
- Pre-reset: t=0, reset=0 from time 0 for 5 cycles -> q/qb X (undefined) until the first reset edge; after it, q=0, qb=1. Also check WIDTH=4, RESET_VAL=4'b1010, t=4'b0110 for one cycle after reset -> q=4'b1100, qb=4'b0011.
